// File: rtl/lmc_dec_display.sv
// lmc_dec_display: sequential binary-to-BCD converter driving DIGITS active-low 7-segment displays.
// Define LMC_DEC_BLANK_EN to blank leading zeros (digit 0 always shown).
module lmc_dec_display #(
    parameter int IN_W   = 11,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_value,
    output logic                  busy,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex_n
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IN_W-1:0]     bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d, adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovfn_q, ovfn_d;
    logic                ovf_q, ovf_d;
    logic [7*DIGITS-1:0] hex_q, hex_d, segs;
`ifdef LMC_DEC_BLANK_EN
    logic                lead;
`endif

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    always_comb begin
        adj  = bcd_q;
        segs = '1;
`ifdef LMC_DEC_BLANK_EN
        lead = 1'b1;
`endif
        for (int k = 0; k < DIGITS; k++)
            adj[4*k+:4] = (bcd_q[4*k+:4] >= 4'd5) ? bcd_q[4*k+:4] + 4'd3 : bcd_q[4*k+:4];
        // Walk from the most significant digit so leading-zero status propagates downward.
        for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LMC_DEC_BLANK_EN
            lead = lead && (bcd_q[4*k+:4] == 4'd0) && (k != 0);
            segs[7*k+:7] = lead ? 7'h7F : seg(bcd_q[4*k+:4]);
`else
            segs[7*k+:7] = seg(bcd_q[4*k+:4]);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovfn_d  = ovfn_q;
        ovf_d   = ovf_q;
        hex_d   = hex_q;
        case (state_q)
            IDLE: if (in_valid) begin
                bin_d   = in_value;
                bcd_d   = '0;
                ovfn_d  = 64'(in_value) >= LIMIT;
                cnt_d   = CW'(IN_W);
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d   = {adj[BW-2:0], bin_q[IN_W-1]};
                bin_d   = bin_q << 1;
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? COMMIT : SHIFT;
            end
            COMMIT: begin
                hex_d   = ovfn_q ? {DIGITS{7'h3F}} : segs;
                ovf_d   = ovfn_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovfn_q  <= 1'b0;
            ovf_q   <= 1'b0;
            hex_q   <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovfn_q  <= ovfn_d;
            ovf_q   <= ovf_d;
            hex_q   <= hex_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = !in_ready;
    assign ovf      = ovf_q;
    assign hex_n    = hex_q;
endmodule

// File: tb/tb_lmc_dec_display.sv
// tb_lmc_dec_display: drives a 11-bit/3-digit and a 32-bit/8-digit instance against a decimal reference model.
module tb_lmc_dec_display;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  vld = '0;
    logic [31:0] val = '0;
    logic [1:0]  rdy, bsy, ov;
    logic [20:0] hex_a;
    logic [55:0] hex_b;
    int          checks = 0;
    int          errors = 0;
    logic [55:0] prev_hex [2];
    logic        prev_ovf [2];
    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    lmc_dec_display #(.IN_W(11), .DIGITS(3)) dut_a (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_value(val[10:0]), .busy(bsy[0]), .ovf(ov[0]), .hex_n(hex_a));

    lmc_dec_display #(.IN_W(32), .DIGITS(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_value(val), .busy(bsy[1]), .ovf(ov[1]), .hex_n(hex_b));

    function automatic logic [55:0] blank_hex(input int w);
        return w != 0 ? {56{1'b1}} : {35'h0, {21{1'b1}}};
    endfunction

    function automatic logic [55:0] obs_hex(input int w);
        return w != 0 ? hex_b : {35'h0, hex_a};
    endfunction

    function automatic logic model_ovf(input int w, input logic [31:0] v);
        longint x = (w != 0) ? longint'(v) : longint'(v[10:0]);
        return x >= ((w != 0) ? 64'd100000000 : 64'd1000);
    endfunction

    function automatic logic [55:0] model_hex(input int w, input logic [31:0] v);
        int nd = (w != 0) ? 8 : 3;
        longint x = (w != 0) ? longint'(v) : longint'(v[10:0]);
        longint orig = x;
        longint pw = 1;
        logic [55:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            if (model_ovf(w, v)) r[7*i+:7] = 7'h3F;
            else begin
                r[7*i+:7] = SEG[x % 10];
`ifdef LMC_DEC_BLANK_EN
                if (i > 0 && orig < pw) r[7*i+:7] = 7'h7F;
`endif
            end
            x  = x / 10;
            pw = pw * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int w, input logic [31:0] v, input bit hold);
        int inw = (w != 0) ? 32 : 11;
        int n = 0;
        logic [55:0] eh;
        while (!rdy[w] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 64'(rdy[w]), 64'd1);
        vld[w] = 1'b1;
        val = v;
        @(posedge clk); #1;
        if (hold) val = 32'd456;
        else vld[w] = 1'b0;
        for (int i = 1; i <= inw; i++) begin
            @(posedge clk); #1;
            chk("hold_hex", 64'(obs_hex(w)), 64'(prev_hex[w]));
            chk("busy_mid", 64'({bsy[w], rdy[w], ov[w]}), 64'({1'b1, 1'b0, prev_ovf[w]}));
        end
        @(posedge clk); #1;
        eh = model_hex(w, v);
        chk("hex_commit", 64'(obs_hex(w)), 64'(eh));
        chk("ovf_commit", 64'(ov[w]), 64'(model_ovf(w, v)));
        chk("idle_after", 64'({bsy[w], rdy[w]}), 64'b01);
        prev_hex[w] = eh;
        prev_ovf[w] = model_ovf(w, v);
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            prev_hex[w] = blank_hex(w);
            prev_ovf[w] = 1'b0;
        end
        #12;
        chk("rst_hex_a", 64'(hex_a), 64'h1FFFFF);
        chk("rst_hex_b", 64'(hex_b), 64'h00FFFFFFFFFFFFFF);
        chk("rst_flags", 64'({rdy, bsy, ov}), 64'b11_00_00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        send(0, 32'd0, 1'b0);
        send(0, 32'd999, 1'b0);
        send(0, 32'd1000, 1'b0);
        send(0, 32'd2047, 1'b0);
        send(0, 32'd42, 1'b0);
        send(0, 32'd123, 1'b1);
        send(0, 32'd456, 1'b0);
        for (int i = 0; i < 8; i++) send(0, 32'($urandom_range(0, 2047)), 1'b0);
        send(1, 32'd99999999, 1'b0);
        send(1, 32'd100000000, 1'b0);
        send(1, 32'd0, 1'b0);
        send(1, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < 3; i++) send(1, 32'($urandom_range(0, 99999999)), 1'b0);
        for (int i = 0; i < 3; i++) send(1, $urandom, 1'b0);
        vld[0] = 1'b1;
        val = 32'd777;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_hex_a", 64'(hex_a), 64'h1FFFFF);
        chk("abort_hex_b", 64'(hex_b), 64'h00FFFFFFFFFFFFFF);
        chk("abort_flags", 64'({rdy, bsy, ov}), 64'b11_00_00);
        @(negedge clk);
        reset = 1'b0;
        for (int w = 0; w < 2; w++) begin
            prev_hex[w] = blank_hex(w);
            prev_ovf[w] = 1'b0;
        end
        send(0, 32'd42, 1'b0);
        send(1, 32'd12345, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
